// File: rtl/mem_pkg.sv
// Shared types for the MEM pipeline stage: FSM states, byte-enable constants
// and the EX/MEM and MEM/WB pipeline register layouts.
package mem_pkg;

   typedef enum logic {MS_IDLE = 1'b0, MS_WAIT = 1'b1} mem_state_t;

   localparam logic [3:0] BE_WORD = 4'b1111;

   typedef struct packed {
      logic [31:0] alu_result;
      logic [31:0] write_data;
      logic        reg_write;
      logic        memto_reg;
      logic        mem_write;
      logic        byte_acc;
      logic [3:0]  wa3;
   } exmem_t;

   typedef struct packed {
      logic [31:0] alu_out;
      logic [31:0] read_data;
      logic        reg_write;
      logic        memto_reg;
      logic [3:0]  wa3;
   } memwb_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for data memory accesses: byte enables, store-byte
// replication and load-byte select with zero extension.
module mem_lane_align
   import mem_pkg::*;
(
   input  logic        byte_acc,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);

   always_comb begin
      be        = BE_WORD;
      wdata     = store_data;
      load_data = rdata;
      if (byte_acc) begin
         wdata = {4{store_data[7:0]}};
         case (addr_lo)
            2'd0: begin be = 4'b0001; load_data = {24'h0, rdata[7:0]};   end
            2'd1: begin be = 4'b0010; load_data = {24'h0, rdata[15:8]};  end
            2'd2: begin be = 4'b0100; load_data = {24'h0, rdata[23:16]}; end
            default: begin be = 4'b1000; load_data = {24'h0, rdata[31:24]}; end
         endcase
      end
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: EX/MEM register, req/ack data-memory FSM with timeout,
// pipeline stall generation and the MEM/WB register.
//
//   state   | meaning
//   MS_IDLE | no access outstanding; a memop in EX/MEM requests immediately
//   MS_WAIT | request outstanding, waiting for ack or timeout
module mem_access_stage
   import mem_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ALUResultE,
   input  logic [31:0] WriteDataE,
   input  logic        RegWriteE,
   input  logic        MemtoRegE,
   input  logic        MemWriteE,
   input  logic        ByteE,
   input  logic [3:0]  WA3E,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        stallM,
   output logic        bus_err,
   output logic [31:0] ALUOutW,
   output logic [31:0] ReadDataW,
   output logic        RegWriteW,
   output logic        MemtoRegW,
   output logic [3:0]  WA3W
);

   localparam int CW = $clog2(TIMEOUT);

   exmem_t        exm;
   memwb_t        mwb, mwb_next;
   mem_state_t    state, state_next;
   logic [CW-1:0] cnt;
   logic          memop, timeout, stall;
   logic [3:0]    lane_be;
   logic [31:0]   lane_wdata, load_data;

   assign memop = exm.mem_write | exm.memto_reg;

   mem_lane_align u_align (
      .byte_acc   (exm.byte_acc),
      .addr_lo    (exm.alu_result[1:0]),
      .store_data (exm.write_data),
      .rdata      (mem_rdata),
      .be         (lane_be),
      .wdata      (lane_wdata),
      .load_data  (load_data)
   );

   // Counter covers the whole access including its first (IDLE) cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= MS_IDLE;
         cnt     <= '0;
         bus_err <= 1'b0;
      end else begin
         state <= state_next;
         if (stall) cnt <= cnt + CW'(1);
         else       cnt <= '0;
         if (timeout) bus_err <= 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         MS_IDLE: if (memop && !mem_ack) state_next = MS_WAIT;
         MS_WAIT: if (mem_ack || timeout) state_next = MS_IDLE;
         default: state_next = MS_IDLE;
      endcase
   end

   always_comb begin
      timeout   = (state == MS_WAIT) && (cnt == CW'(TIMEOUT - 1)) && !mem_ack;
      stall     = memop && !(mem_ack || timeout);
      mem_req   = memop;
      mem_we    = memop & exm.mem_write;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_be    = '0;
      if (memop) begin
         mem_addr  = exm.byte_acc ? exm.alu_result : {exm.alu_result[31:2], 2'b00};
         mem_wdata = exm.mem_write ? lane_wdata : '0;
         mem_be    = lane_be;
      end
   end

   assign stallM = stall;

   always_comb begin
      mwb_next = '0;
      if (!stall) begin
         mwb_next.alu_out   = exm.alu_result;
         mwb_next.read_data = (exm.memto_reg && mem_ack) ? load_data : '0;
         mwb_next.reg_write = exm.reg_write;
         mwb_next.memto_reg = exm.memto_reg;
         mwb_next.wa3       = exm.wa3;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         exm <= '0;
         mwb <= '0;
      end else begin
         if (!stall) begin
            exm.alu_result <= ALUResultE;
            exm.write_data <= WriteDataE;
            exm.reg_write  <= RegWriteE;
            exm.memto_reg  <= MemtoRegE;
            exm.mem_write  <= MemWriteE;
            exm.byte_acc   <= ByteE;
            exm.wa3        <= WA3E;
         end
         mwb <= mwb_next;
      end
   end

   assign ALUOutW   = mwb.alu_out;
   assign ReadDataW = mwb.read_data;
   assign RegWriteW = mwb.reg_write;
   assign MemtoRegW = mwb.memto_reg;
   assign WA3W      = mwb.wa3;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus a
// randomized instruction stream checked against a per-instruction model.
module tb_mem_access_stage;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] ALUResultE, WriteDataE;
   logic        RegWriteE, MemtoRegE, MemWriteE, ByteE;
   logic [3:0]  WA3E;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        stallM, bus_err;
   logic [31:0] ALUOutW, ReadDataW;
   logic        RegWriteW, MemtoRegW;
   logic [3:0]  WA3W;

   int errors = 0;
   int checks = 0;
   logic exp_err = 1'b0;

   always #5 clk = ~clk;

   mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .RegWriteE(RegWriteE),
      .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE), .ByteE(ByteE), .WA3E(WA3E),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .stallM(stallM), .bus_err(bus_err),
      .ALUOutW(ALUOutW), .ReadDataW(ReadDataW), .RegWriteW(RegWriteW),
      .MemtoRegW(MemtoRegW), .WA3W(WA3W)
   );

   task automatic set_e(input logic [31:0] a, input logic [31:0] d, input logic rw,
                        input logic m2r, input logic mw, input logic bt, input logic [3:0] wa);
      ALUResultE = a; WriteDataE = d; RegWriteE = rw;
      MemtoRegE = m2r; MemWriteE = mw; ByteE = bt; WA3E = wa;
   endtask

   // Issue one instruction and follow it through MEM to WB; ack arrives
   // 'delay' cycles after the instruction enters MEM (never, if delay >= TIMEOUT).
   task automatic run_instr(input logic [31:0] a, input logic [31:0] d, input logic rw,
                            input logic m2r, input logic mw, input logic bt,
                            input logic [3:0] wa, input int delay, input logic [31:0] rd);
      logic        memop, done, timed_out, exp_stall;
      logic [31:0] exp_addr, exp_wdata, exp_rd;
      logic [3:0]  exp_be;
      int          cyc, nstall, exp_nstall;
      memop     = mw | m2r;
      exp_addr  = bt ? a : (a & ~32'h3);
      exp_be    = bt ? (4'b0001 << a[1:0]) : 4'hF;
      exp_wdata = bt ? {4{d[7:0]}} : d;
      exp_rd    = bt ? ((rd >> (8 * a[1:0])) & 32'hFF) : rd;
      exp_nstall = !memop ? 0 : (delay < TIMEOUT - 1 ? delay : TIMEOUT - 1);
      set_e(a, d, rw, m2r, mw, bt, wa);
      @(posedge clk); #1;
      set_e($urandom, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, 4'($urandom));
      cyc = 0; done = 1'b0; timed_out = 1'b0; nstall = 0;
      while (!done) begin
         mem_ack   = memop ? (cyc == delay) : 1'($urandom);
         mem_rdata = (memop && cyc == delay) ? rd : $urandom;
         #1;
         exp_stall = memop && !mem_ack && (cyc < TIMEOUT - 1);
         checks++; if (mem_req !== memop) begin errors++; $display("FAIL mem_req cyc%0d: got %b exp %b", cyc, mem_req, memop); end
         checks++; if (stallM !== exp_stall) begin errors++; $display("FAIL stallM cyc%0d: got %b exp %b", cyc, stallM, exp_stall); end
         if (memop) begin
            checks++; if (mem_we !== mw) begin errors++; $display("FAIL mem_we: got %b exp %b", mem_we, mw); end
            checks++; if (mem_addr !== exp_addr) begin errors++; $display("FAIL mem_addr: got %h exp %h", mem_addr, exp_addr); end
            checks++; if (mem_be !== exp_be) begin errors++; $display("FAIL mem_be: got %b exp %b", mem_be, exp_be); end
            if (mw) begin
               checks++; if (mem_wdata !== exp_wdata) begin errors++; $display("FAIL mem_wdata: got %h exp %h", mem_wdata, exp_wdata); end
            end
         end
         if (stallM) nstall++;
         if (memop && !mem_ack && cyc == TIMEOUT - 1) begin timed_out = 1'b1; exp_err = 1'b1; end
         done = !memop || mem_ack || (cyc == TIMEOUT - 1);
         @(posedge clk); #1;
         mem_ack = 1'b0;
         if (!done) begin
            checks++; if ({RegWriteW, MemtoRegW} !== 2'b00) begin errors++; $display("FAIL bubble cyc%0d: got %b%b exp 00", cyc, RegWriteW, MemtoRegW); end
         end
         cyc++;
      end
      checks++; if (nstall != exp_nstall) begin errors++; $display("FAIL stall_cycles: got %0d exp %0d", nstall, exp_nstall); end
      checks++; if (ALUOutW !== a) begin errors++; $display("FAIL ALUOutW: got %h exp %h", ALUOutW, a); end
      checks++; if (WA3W !== wa) begin errors++; $display("FAIL WA3W: got %0d exp %0d", WA3W, wa); end
      checks++; if ({RegWriteW, MemtoRegW} !== {rw, m2r}) begin errors++; $display("FAIL wb_ctrl: got %b%b exp %b%b", RegWriteW, MemtoRegW, rw, m2r); end
      if (m2r) begin
         checks++; if (ReadDataW !== (timed_out ? 32'h0 : exp_rd)) begin errors++; $display("FAIL ReadDataW: got %h exp %h", ReadDataW, timed_out ? 32'h0 : exp_rd); end
      end
      checks++; if (bus_err !== exp_err) begin errors++; $display("FAIL bus_err: got %b exp %b", bus_err, exp_err); end
   endtask

   task automatic test_reset;
      reset = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
      set_e(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      repeat (2) @(posedge clk);
      #1; reset = 1'b0; #1;
      checks++; if ({mem_req, mem_we, stallM, bus_err, RegWriteW, MemtoRegW} !== 6'b0) begin errors++; $display("FAIL reset_ctrl: got %b exp 000000", {mem_req, mem_we, stallM, bus_err, RegWriteW, MemtoRegW}); end
      checks++; if ({mem_addr, mem_wdata, mem_be} !== 68'h0) begin errors++; $display("FAIL reset_bus: got %h exp 0", {mem_addr, mem_wdata, mem_be}); end
      checks++; if ({ALUOutW, ReadDataW, WA3W} !== 68'h0) begin errors++; $display("FAIL reset_wb: got %h exp 0", {ALUOutW, ReadDataW, WA3W}); end
      exp_err = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_alu;
      run_instr(32'h0000_0010, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 0, 32'h0);
   endtask

   task automatic test_store_load;
      run_instr(32'h0000_0100, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 3, 32'h0);
      run_instr(32'h0000_0103, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd5, 0, 32'hAABBCCDD);
      run_instr(32'h0000_0101, 32'h0000_0012, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1, 32'h0);
      run_instr(32'h0000_0202, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd7, 2, 32'h1234_5678);
   endtask

   task automatic test_back_to_back;
      set_e(32'h40, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1);
      @(posedge clk); #1;
      set_e(32'h84, 32'h55, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
      mem_ack = 1'b1; mem_rdata = 32'h1122_3344; #1;
      checks++; if ({mem_req, stallM, mem_addr} !== {2'b10, 32'h40}) begin errors++; $display("FAIL b2b_first: got %b%b %h exp 10 00000040", mem_req, stallM, mem_addr); end
      @(posedge clk); #1;
      set_e(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      mem_ack = 1'b1; #1;
      checks++; if ({mem_req, mem_we, mem_addr} !== {2'b11, 32'h84}) begin errors++; $display("FAIL b2b_second: got %b%b %h exp 11 00000084", mem_req, mem_we, mem_addr); end
      checks++; if ({RegWriteW, WA3W, ReadDataW} !== {1'b1, 4'd1, 32'h1122_3344}) begin errors++; $display("FAIL b2b_wb: got %b %0d %h exp 1 1 11223344", RegWriteW, WA3W, ReadDataW); end
      @(posedge clk); #1;
      mem_ack = 1'b0; #1;
      checks++; if ({mem_req, stallM, RegWriteW} !== 3'b000) begin errors++; $display("FAIL b2b_end: got %b%b%b exp 000", mem_req, stallM, RegWriteW); end
   endtask

   task automatic test_random;
      for (int i = 0; i < 40; i++) begin
         int op;
         logic rw, m2r, mw, bt;
         op = $urandom_range(0, 4);
         rw  = (op == 0) || (op == 1) || (op == 3);
         m2r = (op == 1) || (op == 3);
         mw  = (op == 2) || (op == 4);
         bt  = (op == 3) || (op == 4);
         run_instr($urandom, $urandom, rw, m2r, mw, bt, 4'($urandom),
                   $urandom_range(0, 4), $urandom);
      end
   endtask

   task automatic test_timeout;
      run_instr(32'h0000_0080, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd9, 100, 32'hFFFF_FFFF);
      run_instr(32'h0000_0044, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 0, 32'h0);
   endtask

   task automatic test_reset_wait;
      set_e(32'h300, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd6);
      @(posedge clk); #1;
      set_e(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      for (int i = 0; i < 3; i++) begin
         mem_ack = 1'b0; #1;
         checks++; if ({mem_req, stallM} !== 2'b11) begin errors++; $display("FAIL rw_wait%0d: got %b%b exp 11", i, mem_req, stallM); end
         @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; exp_err = 1'b0; #1;
      checks++; if ({mem_req, stallM, bus_err, RegWriteW, ALUOutW} !== 36'h0) begin errors++; $display("FAIL rw_after_reset: got %b%b%b%b %h exp 0", mem_req, stallM, bus_err, RegWriteW, ALUOutW); end
      mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D; #1;
      checks++; if ({mem_req, stallM} !== 2'b00) begin errors++; $display("FAIL rw_late_ack: got %b%b exp 00", mem_req, stallM); end
      @(posedge clk); #1;
      mem_ack = 1'b0; #1;
      checks++; if ({RegWriteW, MemtoRegW, ReadDataW, bus_err, mem_req} !== 35'h0) begin errors++; $display("FAIL rw_ignored: got %b%b %h %b%b exp 0", RegWriteW, MemtoRegW, ReadDataW, bus_err, mem_req); end
   endtask

   initial begin
      test_reset;
      test_alu;
      test_store_load;
      test_back_to_back;
      test_random;
      test_timeout;
      test_reset_wait;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
